// File: rtl/expr_calc_if.sv
// Character-in / result-out bundle for the expression calculator.
// master = character producer and result consumer, slave = calculator.
interface expr_calc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [7:0]       in;
  logic             in_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res;
  logic             err;
  logic             res_ack;
  logic             ok;

  modport master (
    output in_valid,
    output in,
    output res_ack,
    input  in_ready,
    input  res_valid,
    input  res,
    input  err,
    input  ok
  );

  modport slave (
    input  in_valid,
    input  in,
    input  res_ack,
    output in_ready,
    output res_valid,
    output res,
    output err,
    output ok
  );
endinterface

// File: rtl/expr_calc.sv
// Streaming single-digit "+"/"*" expression evaluator.
// Multiplication binds tighter than addition; all arithmetic wraps.
module expr_calc #(
  parameter int         WIDTH = 16,
  parameter logic [7:0] TERM  = 8'h3D
) (
  input  logic        clk,
  input  logic        clr,
  expr_calc_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_NUM  = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_ERR  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             mulp_q, mulp_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             rv_q, rv_d;
  logic             err_q, err_d;

  logic             acc;
  logic             is_term;
  logic             is_dig;
  logic             is_add;
  logic             is_mul;
  logic [WIDTH-1:0] dig;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] total;

  assign bus.in_ready  = (state_q != S_DONE);
  assign bus.ok        = (state_q == S_NUM);
  assign bus.res_valid = rv_q;
  assign bus.res       = res_q;
  assign bus.err       = err_q;

  assign acc = bus.in_valid & bus.in_ready;

  // Classes are made disjoint so a digit or operator TERM still decodes cleanly.
  assign is_term = (bus.in == TERM);
  assign is_dig  = (bus.in >= 8'h30) && (bus.in <= 8'h39) && !is_term;
  assign is_add  = (bus.in == 8'h2B) && !is_term;
  assign is_mul  = (bus.in == 8'h2A) && !is_term;

  assign dig   = WIDTH'(bus.in[3:0]);
  assign prod  = term_q * dig;
  assign total = sum_q + term_q;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    term_d  = term_q;
    mulp_d  = mulp_q;
    res_d   = res_q;
    rv_d    = rv_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE, S_OP: begin
        if (acc) begin
          unique case (1'b1)
            is_dig: begin
              state_d = S_NUM;
              term_d  = mulp_q ? prod : dig;
            end
            is_term: begin
              state_d = S_DONE;
              res_d   = '0;
              err_d   = 1'b1;
              rv_d    = 1'b1;
            end
            default: state_d = S_ERR;
          endcase
        end
      end
      S_NUM: begin
        if (acc) begin
          unique case (1'b1)
            is_add: begin
              state_d = S_OP;
              sum_d   = total;
              mulp_d  = 1'b0;
            end
            is_mul: begin
              state_d = S_OP;
              mulp_d  = 1'b1;
            end
            is_term: begin
              state_d = S_DONE;
              res_d   = total;
              err_d   = 1'b0;
              rv_d    = 1'b1;
            end
            default: state_d = S_ERR;
          endcase
        end
      end
      S_ERR: begin
        if (acc && is_term) begin
          state_d = S_DONE;
          res_d   = '0;
          err_d   = 1'b1;
          rv_d    = 1'b1;
        end
      end
      S_DONE: begin
        // res/err stay put so the consumer can still read them after ack.
        if (bus.res_ack) begin
          state_d = S_IDLE;
          sum_d   = '0;
          term_d  = '0;
          mulp_d  = 1'b0;
          rv_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      term_q  <= '0;
      mulp_q  <= 1'b0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      term_q  <= term_d;
      mulp_q  <= mulp_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_expr_calc.sv
// Directed bench for expr_calc with hand-computed expectations.
module tb_expr_calc;

  logic clk = 1'b0;
  logic clr;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  expr_calc_if #(.WIDTH(16)) bus ();

  expr_calc #(.WIDTH(16), .TERM(8'h3D)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    bus.in       = c;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic ack();
    bus.res_ack = 1'b1;
    tick();
    bus.res_ack = 1'b0;
  endtask

  initial begin
    clr          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in       = 8'h00;
    bus.res_ack  = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(bus.in_ready), 1);
    check("rst_ok", 32'(bus.ok), 0);
    check("rst_rv", 32'(bus.res_valid), 0);
    check("rst_res", 32'(bus.res), 0);
    check("rst_err", 32'(bus.err), 0);
    clr = 1'b0;

    // 2+3*4= -> 14
    send("2"); check("p_ok2", 32'(bus.ok), 1);
    send("+"); check("p_okp", 32'(bus.ok), 0);
    send("3"); check("p_ok3", 32'(bus.ok), 1);
    send("*"); check("p_okm", 32'(bus.ok), 0);
    send("4"); check("p_ok4", 32'(bus.ok), 1);
    send("=");
    check("p_rv", 32'(bus.res_valid), 1);
    check("p_res", 32'(bus.res), 14);
    check("p_err", 32'(bus.err), 0);
    check("p_rdy", 32'(bus.in_ready), 0);
    ack();
    check("p_rv0", 32'(bus.res_valid), 0);
    check("p_rdy1", 32'(bus.in_ready), 1);
    check("p_hold", 32'(bus.res), 14);

    // 9^6 wraps to 7153
    send_str("9*9*9*9*9*9=");
    check("w_rv", 32'(bus.res_valid), 1);
    check("w_res", 32'(bus.res), 7153);
    check("w_err", 32'(bus.err), 0);
    ack();

    send_str("3+*4=");
    check("m1_rv", 32'(bus.res_valid), 1);
    check("m1_err", 32'(bus.err), 1);
    check("m1_res", 32'(bus.res), 0);
    ack();

    send("=");
    check("m2_rv", 32'(bus.res_valid), 1);
    check("m2_err", 32'(bus.err), 1);
    check("m2_res", 32'(bus.res), 0);
    ack();

    send("1"); check("m3_ok1", 32'(bus.ok), 1);
    // res_ack outside DONE has no effect
    ack();
    check("m3_ackign", 32'(bus.ok), 1);
    send("2"); check("m3_ok2", 32'(bus.ok), 0);
    send("=");
    check("m3_err", 32'(bus.err), 1);
    check("m3_res", 32'(bus.res), 0);
    ack();

    // backpressure while a result is held
    send_str("1+1=");
    check("b_res", 32'(bus.res), 2);
    bus.in       = "5";
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_rdy0", 32'(bus.in_ready), 0);
      check("b_rv1", 32'(bus.res_valid), 1);
      check("b_res", 32'(bus.res), 2);
    end
    bus.res_ack = 1'b1;
    tick();
    bus.res_ack = 1'b0;
    check("b_rdy1", 32'(bus.in_ready), 1);
    check("b_ok0", 32'(bus.ok), 0);
    tick();
    bus.in_valid = 1'b0;
    check("b_take5", 32'(bus.ok), 1);
    send("=");
    check("b_res5", 32'(bus.res), 5);
    check("b_err", 32'(bus.err), 0);
    ack();

    // reset mid-expression
    send_str("5+");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("r_ok", 32'(bus.ok), 0);
    check("r_rdy", 32'(bus.in_ready), 1);
    send_str("7=");
    check("r_res", 32'(bus.res), 7);
    check("r_err", 32'(bus.err), 0);

    // reset beats a held result and a simultaneous ack
    bus.res_ack = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus.res_ack = 1'b0;
    check("rd_rv", 32'(bus.res_valid), 0);
    check("rd_res", 32'(bus.res), 0);
    check("rd_rdy", 32'(bus.in_ready), 1);

    // wrapping addition: 9^6 + 9^6 = 14306
    send_str("9*9*9*9*9*9+9*9*9*9*9*9=");
    check("wa_res", 32'(bus.res), 14306);
    check("wa_err", 32'(bus.err), 0);
    ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/expr_calc.md
EXPR_CALC -- requirements
Module: expr_calc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the width of the result and accumulators.
REQ-002 SHALL have parameter TERM, default 8'h3D ("="), meaning the expression terminator character.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the character on in is offered.
REQ-006 SHALL have port in, input, 8 bits: ASCII character.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a character this cycle.
REQ-008 SHALL have port res_valid, output, 1 bit: res and err hold a completed expression.
REQ-009 SHALL have port res, output, WIDTH bits: the expression value.
REQ-010 SHALL have port err, output, 1 bit: the completed expression was malformed.
REQ-011 SHALL have port res_ack, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port ok, output, 1 bit: the prefix accepted so far is a well-formed expression.

Function
REQ-013 A character SHALL be accepted only in a cycle with in_valid=1 and in_ready=1; in all other cycles in is ignored.
REQ-014 States: IDLE (expect digit), NUM (after digit), OP (after operator), ERR (malformed, discard until TERM), DONE (result held).
REQ-015 Digit = 8'h30..8'h39; operators = "+" (8'h2B) and "*" (8'h2A); operands are single digits.
REQ-016 IDLE/OP: digit -> NUM; TERM -> DONE with err=1; any other character -> ERR.
REQ-017 NUM: "+" or "*" -> OP; TERM -> DONE with err=0; digit or any other character -> ERR.
REQ-018 ERR: TERM -> DONE with err=1; any other character stays in ERR.
REQ-019 DONE: in_ready=0; res_ack=1 -> IDLE in the next cycle. res_ack SHALL be ignored outside DONE.
REQ-020 in_ready SHALL be 1 in every state except DONE.
REQ-021 Evaluation SHALL use standard precedence, with "*" binding tighter than "+", held in registers sum, term and mulp.
REQ-022 On an accepted digit d: term <= mulp ? term*d : d, truncated to WIDTH.
REQ-023 On "+": sum <= sum+term (mod 2^WIDTH) and mulp <= 0. On "*": mulp <= 1.
REQ-024 On TERM from NUM: res <= sum+term (mod 2^WIDTH). On TERM from any other state: res <= 0.
REQ-025 On every TERM: res_valid <= 1 in the cycle after acceptance.
REQ-026 On leaving DONE: sum, term and mulp SHALL be cleared and res_valid SHALL drop to 0. res and err SHALL hold their values until the next TERM.
REQ-027 ok SHALL be 1 iff state==NUM; this is combinational from the state.
REQ-028 All arithmetic SHALL be unsigned and wrap silently modulo 2^WIDTH; overflow SHALL NOT set err.

Reset
REQ-029 When clr=1 at a clock edge: state <= IDLE; sum, term, mulp and res <= 0; res_valid and err <= 0.
REQ-030 clr SHALL take priority over any simultaneous character or res_ack, including mid-expression and in DONE.
REQ-031 While clr=1, in_ready SHALL read 1 and ok SHALL read 0 after the first edge.

Verification
REQ-032 Stream "2+3*4=" with in_valid=1 every cycle -> one cycle after "=": res_valid=1, res=14, err=0; ok high after each digit.
REQ-033 Stream "9*9*9*9*9*9=" -> res=7153 (531441 mod 65536), err=0.
REQ-034 Malformed input:
- "3+*4=" -> res_valid=1, err=1, res=0.
- "=" alone -> err=1, res=0.
- "12=" -> err=1.
REQ-035 Backpressure: hold in_valid=1 with "5" during DONE for 3 cycles with res_ack=0 -> in_ready=0 and "5" not consumed; pulse res_ack -> next cycle in_ready=1 and "5" accepted.
REQ-036 Reset mid-operation: "5+" then clr for one cycle, then "7=" -> res=7, err=0.
